reg_rotator: RTL and testbench

REG_ROTATOR -- requirements
Module: reg_rotator

---
 rtl/reg_rotator_pkg.sv | 17 +
 rtl/reg_rotator_rot_step_ctrl.sv | 70 +++++++
 rtl/reg_rotator.sv | 111 +++++++++++
 tb/tb_reg_rotator.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/reg_rotator_pkg.sv
// Shared command encoding and controller state type for the reg_rotator block.
package reg_rotator_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ROT  = 2'b01,
        OP_SWAP = 2'b10,
        OP_CLR  = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_STEP = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/reg_rotator_rot_step_ctrl.sv
// Command sequencer: accepts one command at a time, counts rotation steps, pulses done.
module rot_step_ctrl
    import reg_rotator_pkg::*;
#(
    parameter int IDXW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    input  cmd_op_e         cmd_op,
    input  logic [IDXW-1:0] cmd_steps,
    output logic            step_en,
    output logic            done,
    output logic            busy,
    output logic            ready
);

    state_e          state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_en = 1'b0;
        done    = 1'b0;
        busy    = 1'b1;
        ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy  = 1'b0;
                ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_op == OP_ROT && cmd_steps != '0) begin
                        state_d = ST_STEP;
                        cnt_d   = cmd_steps;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_STEP: begin
                step_en = 1'b1;
                cnt_d   = cnt_q - IDXW'(1);
                if (cnt_q == IDXW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/reg_rotator.sv
// Register array with LOAD/ROT/SWAP/CLR commands and a combinational read port.
// Define REG_ROTATOR_REVERSE_EN to let cmd_dir=1 rotate right; otherwise every step rotates left.
module reg_rotator
    import reg_rotator_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 3,
    localparam int IDXW  = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDXW-1:0]  cmd_idx,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [IDXW-1:0]  cmd_steps,
    input  logic             cmd_dir,
    input  logic [IDXW-1:0]  rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done
);

    cmd_op_e          op;
    logic             accept;
    logic             step_en;
    logic             rot_right_q;
    logic [WIDTH-1:0] r_q [DEPTH];
    logic [WIDTH-1:0] r_d [DEPTH];

    assign op     = cmd_op_e'(cmd_op);
    assign accept = cmd_valid && cmd_ready;

    rot_step_ctrl #(
        .IDXW (IDXW)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (op),
        .cmd_steps (cmd_steps),
        .step_en   (step_en),
        .done      (done),
        .busy      (busy),
        .ready     (cmd_ready)
    );

`ifdef REG_ROTATOR_REVERSE_EN
    // Direction is held for the whole rotation; cmd_dir may change after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_right_q <= 1'b0;
        end else if (accept && op == OP_ROT) begin
            rot_right_q <= cmd_dir;
        end
    end
`else
    logic unused_cmd_dir;
    assign unused_cmd_dir = cmd_dir;
    assign rot_right_q    = 1'b0;
`endif

    always_comb begin
        r_d = r_q;
        if (step_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rot_right_q) r_d[i] = r_q[(i + DEPTH - 1) % DEPTH];
                else             r_d[i] = r_q[(i + 1) % DEPTH];
            end
        end else if (accept) begin
            // Out-of-range indices match no register, so LOAD/SWAP fall through unchanged.
            case (op)
                OP_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (int'(cmd_idx) == i) r_d[i] = cmd_data;
                    end
                end
                OP_SWAP: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (int'(cmd_idx) == i) begin
                            r_d[i]                 = r_q[(i + 1) % DEPTH];
                            r_d[(i + 1) % DEPTH]   = r_q[i];
                        end
                    end
                end
                OP_CLR: begin
                    for (int i = 0; i < DEPTH; i++) r_d[i] = '0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the array is small flop storage with a defined reset value, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(rd_idx) == i) rd_data = r_q[i];
        end
    end

endmodule

// File: tb/tb_reg_rotator.sv
// Directed bench for reg_rotator (WIDTH=32, DEPTH=3): vector table plus reset/busy corner sequences.
module tb_reg_rotator;
    import reg_rotator_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [1:0]  cmd_idx = '0;
    logic [31:0] cmd_data = '0;
    logic [1:0]  cmd_steps = '0;
    logic        cmd_dir = 1'b0;
    logic [1:0]  rd_idx = '0;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_rotator #(.WIDTH(32), .DEPTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_idx   (cmd_idx),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .cmd_dir   (cmd_dir),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        cmd_op_e     op;
        logic [1:0]  idx;
        logic [31:0] data;
        logic [1:0]  steps;
        logic        dir;
        logic [31:0] e0, e1, e2;
        int          ebusy;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string name, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2);
        rd_idx = 2'd0; #1; check({name, " r0"}, rd_data, e0);
        rd_idx = 2'd1; #1; check({name, " r1"}, rd_data, e1);
        rd_idx = 2'd2; #1; check({name, " r2"}, rd_data, e2);
        rd_idx = 2'd3; #1; check({name, " rd oob"}, rd_data, 32'd0);
    endtask

    // Issue one command, then watch busy/done until the block returns to idle.
    task automatic run_cmd(input string name, input cmd_op_e op, input logic [1:0] idx,
                           input logic [31:0] data, input logic [1:0] steps, input logic dir,
                           input int ebusy, input bit inject);
        int bc;
        int dc;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = idx;
        cmd_data  = data;
        cmd_steps = steps;
        cmd_dir   = dir;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 32'hFFFF_FFFF;
        cmd_steps = 2'd3;
        cmd_dir   = ~dir;
        bc = 0;
        dc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (inject && c == 1) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_CLR;
            end else begin
                cmd_valid = 1'b0;
            end
            if (busy) bc++;
            if (done) dc++;
            if (!busy) break;
        end
        cmd_valid = 1'b0;
        check({name, " idle at end"}, {31'd0, busy}, 32'd0);
        check({name, " ready at end"}, {31'd0, cmd_ready}, 32'd1);
        check({name, " busy cycles"}, bc, ebusy);
        check({name, " done pulses"}, dc, 32'd1);
    endtask

    function automatic vec_t mk(cmd_op_e op, logic [1:0] idx, logic [31:0] data, logic [1:0] steps,
                                logic dir, logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
                                int ebusy);
        vec_t v;
        v.op = op; v.idx = idx; v.data = data; v.steps = steps; v.dir = dir;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.ebusy = ebusy;
        return v;
    endfunction

    initial begin
        int dc;

        vecs[0]  = mk(OP_LOAD, 2'd0, 32'd1, 2'd0, 1'b0, 1, 0, 0, 1);
        vecs[1]  = mk(OP_LOAD, 2'd1, 32'd2, 2'd0, 1'b0, 1, 2, 0, 1);
        vecs[2]  = mk(OP_LOAD, 2'd2, 32'd3, 2'd0, 1'b0, 1, 2, 3, 1);
        vecs[3]  = mk(OP_ROT,  2'd0, 32'd0, 2'd1, 1'b0, 2, 3, 1, 2);
        vecs[4]  = mk(OP_CLR,  2'd0, 32'd0, 2'd0, 1'b0, 0, 0, 0, 1);
        vecs[5]  = mk(OP_LOAD, 2'd0, 32'd1, 2'd0, 1'b0, 1, 0, 0, 1);
        vecs[6]  = mk(OP_LOAD, 2'd1, 32'd2, 2'd0, 1'b0, 1, 2, 0, 1);
        vecs[7]  = mk(OP_LOAD, 2'd2, 32'd3, 2'd0, 1'b0, 1, 2, 3, 1);
        vecs[8]  = mk(OP_SWAP, 2'd2, 32'd0, 2'd0, 1'b0, 3, 2, 1, 1);
        vecs[9]  = mk(OP_SWAP, 2'd3, 32'd0, 2'd0, 1'b0, 3, 2, 1, 1);
        vecs[10] = mk(OP_ROT,  2'd0, 32'd0, 2'd0, 1'b0, 3, 2, 1, 1);
        vecs[11] = mk(OP_LOAD, 2'd3, 32'd9, 2'd0, 1'b0, 3, 2, 1, 1);
        vecs[12] = mk(OP_SWAP, 2'd0, 32'd0, 2'd0, 1'b0, 2, 3, 1, 1);
        vecs[13] = mk(OP_ROT,  2'd0, 32'd0, 2'd2, 1'b0, 1, 2, 3, 3);
`ifdef REG_ROTATOR_REVERSE_EN
        vecs[14] = mk(OP_ROT,  2'd0, 32'd0, 2'd1, 1'b1, 3, 1, 2, 2);
`else
        vecs[14] = mk(OP_ROT,  2'd0, 32'd0, 2'd1, 1'b1, 2, 3, 1, 2);
`endif

        // Reset state, held across a few edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_regs("reset", 0, 0, 0);
        check("reset ready", {31'd0, cmd_ready}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            run_cmd(nm, vecs[i].op, vecs[i].idx, vecs[i].data, vecs[i].steps, vecs[i].dir,
                    vecs[i].ebusy, 1'b0);
            check_regs(nm, vecs[i].e0, vecs[i].e1, vecs[i].e2);
        end

        // steps is 2 bits wide, so 3 is the longest rotation; a stray command mid-rotation must be dropped.
        run_cmd("ld0", OP_LOAD, 2'd0, 32'd1, 2'd0, 1'b0, 1, 1'b0);
        run_cmd("ld1", OP_LOAD, 2'd1, 32'd2, 2'd0, 1'b0, 1, 1'b0);
        run_cmd("ld2", OP_LOAD, 2'd2, 32'd3, 2'd0, 1'b0, 1, 1'b0);
        run_cmd("rot3 inject", OP_ROT, 2'd0, 32'd0, 2'd3, 1'b0, 4, 1'b1);
        check_regs("rot3 inject", 1, 2, 3);

        // Asynchronous reset during the second step of a 3-step rotation.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_ROT; cmd_steps = 2'd3; cmd_dir = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrot busy before reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrot ready", {31'd0, cmd_ready}, 32'd1);
        check("midrot busy", {31'd0, busy}, 32'd0);
        check("midrot done", {31'd0, done}, 32'd0);
        check_regs("midrot", 0, 0, 0);
        dc = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) dc++;
        end
        check("midrot no done", dc, 32'd0);

        // First acceptance on the first rising edge after release.
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_cmd("post-reset load", OP_LOAD, 2'd1, 32'hA5A5_0001, 2'd0, 1'b0, 1, 1'b0);
        check_regs("post-reset load", 0, 32'hA5A5_0001, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
